// File: rtl/cgra_cfg_sequencer.sv
// rtl/cgra_cfg_sequencer.sv - loads per-PE config registers from a word stream, then releases the array to run
module cgra_cfg_sequencer #(
  parameter int WIDTH  = 64,
  parameter int NUM_PE = 16,
  localparam int IDX_W = $clog2(NUM_PE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  base_pe,
  input  logic [IDX_W:0]    num_words,
  input  logic              abort,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WIDTH-1:0]  cfg_data,
  output logic [NUM_PE-1:0] cfg_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              run
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  localparam logic [IDX_W:0]    MAX_WORDS = (IDX_W + 1)'(NUM_PE);
  localparam logic [NUM_PE-1:0] WE_ONE    = NUM_PE'(1);

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   remaining;
  logic             count_ok;

  assign count_ok = (num_words != '0) && (num_words <= MAX_WORDS);

  // run and done are pure state decodes, so they can never disagree with busy
  assign s_ready = (state == LOAD) && !abort;
  assign busy    = (state == LOAD) || (state == DONE);
  assign done    = (state == DONE);
  assign run     = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      cfg_data  <= '0;
      cfg_we    <= '0;
      err       <= 1'b0;
    end else begin
      cfg_we <= '0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            if (count_ok) begin
              ptr       <= base_pe;
              remaining <= num_words;
              err       <= 1'b0;
              state     <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          // abort masks s_ready, so a beat arriving with abort is dropped
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (s_valid) begin
            cfg_data  <= s_data;
            cfg_we    <= WE_ONE << ptr;
            ptr       <= ptr + IDX_W'(1);
            remaining <= remaining - (IDX_W + 1)'(1);
            if (remaining == (IDX_W + 1)'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// tb/tb_cgra_cfg_sequencer.sv - scoreboard bench for cgra_cfg_sequencer
module tb_cgra_cfg_sequencer;

  localparam int WIDTH  = 64;
  localparam int NUM_PE = 16;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  base_pe;
  logic [IDX_W:0]    num_words;
  logic              abort;
  logic [WIDTH-1:0]  s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  cfg_data;
  logic [NUM_PE-1:0] cfg_we;
  logic              busy;
  logic              done;
  logic              err;
  logic              run;

  cgra_cfg_sequencer #(.WIDTH(WIDTH), .NUM_PE(NUM_PE)) dut (
    .clk(clk), .rst(rst), .start(start), .base_pe(base_pe), .num_words(num_words),
    .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_data(cfg_data), .cfg_we(cfg_we), .busy(busy), .done(done), .err(err), .run(run)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cur_ptr = 0;
  logic last_acc;
  logic last_ready;
  int pe_q[$];
  logic [WIDTH-1:0] dat_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after a negedge; acceptance is judged before the edge
  // and the resulting write is scored at the following negedge.
  task automatic cycle();
    int p;
    logic [WIDTH-1:0] d;
    logic [NUM_PE-1:0] e;
    #1;
    last_ready = s_ready;
    last_acc   = s_valid && s_ready && !rst;
    if (last_acc) begin
      pe_q.push_back(cur_ptr);
      dat_q.push_back(s_data);
      cur_ptr = (cur_ptr + 1) % NUM_PE;
    end
    @(posedge clk);
    @(negedge clk);
    if (last_acc) begin
      p = pe_q.pop_front();
      d = dat_q.pop_front();
      e = NUM_PE'(1) << p;
      check_eq("cfg_we", 64'(cfg_we), 64'(e));
      check_eq("cfg_data", cfg_data, d);
    end else if (cfg_we != '0) begin
      check_eq("we_spurious", 64'(cfg_we), 64'd0);
    end
    if (done) done_cnt++;
  endtask

  task automatic start_load(input int base, input int n);
    start     = 1'b1;
    base_pe   = IDX_W'(base);
    num_words = (IDX_W + 1)'(n);
    if (n >= 1 && n <= NUM_PE) cur_ptr = base;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [WIDTH-1:0] d0, input logic [15:0] pat,
                      input int plen, input int abort_idx);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 64) begin
      s_valid = pat[cyc % plen];
      s_data  = d0 + WIDTH'(got);
      abort   = s_valid && (got == abort_idx);
      cycle();
      if (abort) begin
        check_eq("abort_ready", 64'(last_ready), 64'd0);
        abort   = 1'b0;
        s_valid = 1'b0;
        return;
      end
      if (last_acc) got++;
      cyc++;
    end
    s_valid = 1'b0;
    if (got < n) check_eq("send_timeout", 64'(got), 64'(n));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_cfg_data"}, cfg_data, 64'd0);
    check_eq({tag, "_cfg_we"}, 64'(cfg_we), 64'd0);
    check_eq({tag, "_flags"}, {59'd0, done, err, run, busy, s_ready}, 64'd0);
  endtask

  task automatic finish_and_run(input string tag, input int dc0);
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_busy_done"}, 64'(busy), 64'd1);
    check_eq({tag, "_run_done"}, 64'(run), 64'd0);
    cycle();
    check_eq({tag, "_run"}, 64'(run), 64'd1);
    check_eq({tag, "_busy_run"}, 64'(busy), 64'd0);
    check_eq({tag, "_ready_run"}, 64'(s_ready), 64'd0);
    check_eq({tag, "_done_cnt"}, 64'(done_cnt - dc0), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int dc0;
    rst = 1'b1; start = 1'b0; base_pe = '0; num_words = '0;
    abort = 1'b0; s_data = '0; s_valid = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    check_zero("reset");
    rst = 1'b0;

    // basic load
    dc0 = done_cnt;
    start_load(0, 4);
    check_eq("basic_ready", 64'(s_ready), 64'd1);
    send(4, 64'hA0, 16'h1, 1, -1);
    finish_and_run("basic", dc0);

    // reconfigure from RUN, with a start during LOAD ignored
    dc0 = done_cnt;
    start_load(5, 2);
    check_eq("reconf_run_low", 64'(run), 64'd0);
    check_eq("reconf_busy", 64'(busy), 64'd1);
    start = 1'b1; num_words = '0;
    cycle();
    start = 1'b0;
    check_eq("reconf_start_ignored", 64'(err), 64'd0);
    send(2, 64'hB0, 16'h1, 1, -1);
    finish_and_run("reconf", dc0);

    // invalid start from RUN
    start_load(0, 17);
    check_eq("run_invalid_err", 64'(err), 64'd1);
    check_eq("run_invalid_run", 64'(run), 64'd1);

    // wrap-around with stalls 1,0,0,1,1,0,1
    dc0 = done_cnt;
    start_load(14, 4);
    check_eq("wrap_err_cleared", 64'(err), 64'd0);
    send(4, 64'hC0, 16'b1011001, 7, -1);
    finish_and_run("wrap", dc0);

    // abort on the 3rd of 5 beats
    dc0 = done_cnt;
    start_load(3, 5);
    send(5, 64'hD0, 16'h1, 1, 2);
    check_eq("abort_err", 64'(err), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_run", 64'(run), 64'd0);
    s_valid = 1'b1; s_data = 64'hDF;
    cycle();
    cycle();
    s_valid = 1'b0;
    check_eq("abort_no_done", 64'(done_cnt - dc0), 64'd0);

    // invalid starts in IDLE
    do_reset();
    start_load(0, 0);
    check_eq("zero_err", 64'(err), 64'd1);
    check_eq("zero_idle", {62'd0, busy, s_ready}, 64'd0);
    do_reset();
    start_load(0, 17);
    check_eq("big_err", 64'(err), 64'd1);
    check_eq("big_idle", {62'd0, busy, s_ready}, 64'd0);
    dc0 = done_cnt;
    start_load(2, 1);
    check_eq("valid_clears_err", 64'(err), 64'd0);
    send(1, 64'h77, 16'h1, 1, -1);
    finish_and_run("single", dc0);

    // reset mid-load after 1 of 3 beats
    start_load(8, 3);
    send(1, 64'hE0, 16'h1, 1, -1);
    rst = 1'b1; s_valid = 1'b1; s_data = 64'hE1;
    cycle();
    rst = 1'b0;
    check_zero("midrst");
    cycle();
    cycle();
    s_valid = 1'b0;
    check_eq("midrst_ready", 64'(s_ready), 64'd0);

    // full array load starting mid-array
    dc0 = done_cnt;
    start_load(9, 16);
    send(16, 64'hF00, 16'h1, 1, -1);
    finish_and_run("full", dc0);

    check_eq("sb_drained", 64'(pe_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_cfg_sequencer.md
Name: cgra_cfg_sequencer

Overview:
- Sequences loading of per-PE configuration registers in the CGRA array from a single valid/ready word stream, then releases the array to run.
- Sits between the host/config DMA stream and the bank of per-PE width-bit config registers; it drives their shared data bus and one-hot write enables.
- Tracks load progress, signals completion and errors, and holds the array's run enable low while configuration is in flight.

Parameters:
- WIDTH, 64, config word width in bits.
- NUM_PE, 16, number of PE config registers; power of two, at least 2.
- IDX_W, $clog2(NUM_PE), PE index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle request to begin a load
- base_pe  in  IDX_W  first PE index to write; sampled on an accepted start
- num_words  in  IDX_W+1  number of words to load, 1..NUM_PE; sampled on an accepted start
- abort  in  1  cancels a load in progress
- s_data  in  WIDTH  config word stream data
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- cfg_data  out  WIDTH  registered write data to the PE config registers
- cfg_we  out  NUM_PE  registered one-hot write enable; at most one bit set
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse when a load completes
- err  out  1  sticky error flag
- run  out  1  array run enable

Behaviour:
- Reset (rst=1 at posedge) puts the block in IDLE and clears all outputs: cfg_data=0, cfg_we=0, done=0, err=0, run=0. s_ready and busy are then 0 because they decode from state. Reset mid-load abandons the load with no further cfg_we pulses.
- States are IDLE, LOAD, DONE and RUN.
- IDLE, start=1:
  - num_words in 1..NUM_PE: latch ptr=base_pe and remaining=num_words, clear err, go to LOAD.
  - num_words=0 or num_words>NUM_PE: set err=1 and stay in IDLE.
- RUN, start=1: the same checks as IDLE apply. On a valid start, run drops to 0 on the same edge that enters LOAD. On an invalid start, set err=1 and stay in RUN.
- start is ignored in LOAD and DONE.
- s_ready = (state==LOAD) && !abort. This is combinational. A beat is accepted when s_valid && s_ready.
- LOAD, on each accepted beat, at the next edge:
  - cfg_data <= s_data and cfg_we <= (1<<ptr), so write latency is 1 cycle.
  - ptr <= ptr+1, wrapping modulo NUM_PE (e.g. base 14 with 4 words on NUM_PE=16 writes PEs 14, 15, 0, 1).
  - remaining <= remaining-1.
- LOAD, no beat accepted: cfg_we <= 0 and cfg_data holds its last value. s_valid gaps of any length are tolerated.
- LOAD, last beat (remaining==1 when accepted): go to DONE on that edge.
- DONE lasts one cycle. done=1 and the final cfg_we pulse are both visible in DONE. Next state is RUN.
- RUN: run=1 and busy=0.
- abort=1 in LOAD: no beat is accepted that cycle, so abort wins over a simultaneous beat. Go to IDLE, set err=1, cfg_we <= 0, run stays 0. Words already written are not undone.
- abort in IDLE, DONE or RUN has no effect.
- err stays set until the next valid start or rst.
- num_words=NUM_PE writes every PE exactly once.
- cfg_we is never multi-hot.

Test Plan:
- Basic load:
  - Stimulus: rst, then start with base_pe=0, num_words=4, and 4 back-to-back beats 0xA0..0xA3.
  - Required: cfg_we=0x0001, 0x0002, 0x0004, 0x0008 on consecutive cycles with matching cfg_data, each 1 cycle after its beat; done pulses 1 cycle in the cycle after the last beat edge; run=1 the next cycle; s_ready=0 outside LOAD.
- Wrap-around with stalls:
  - Stimulus: base_pe=14, num_words=4, s_valid toggling 1,0,0,1,1,0,1.
  - Required: writes to PEs 14, 15, 0, 1 in order; cfg_we=0 on stall cycles; done exactly once.
- Invalid start:
  - Stimulus: num_words=0, then num_words=17 (NUM_PE=16).
  - Required: err=1 and state stays IDLE, with s_ready=0 and no cfg_we. A following valid start clears err.
- Abort:
  - Stimulus: abort asserted together with the 3rd of 5 beats.
  - Required: s_ready=0 that cycle; only PEs base and base+1 written; err=1; done never pulses; run=0.
- Reconfigure from RUN:
  - Stimulus: while run=1, start with num_words=2.
  - Required: run=0 the cycle after start; 2 writes; done pulse; run=1 again; start during LOAD ignored.
- Reset mid-load:
  - Stimulus: rst after 1 of 3 beats.
  - Required: all outputs 0 the next cycle; no further cfg_we; s_ready=0.
